multicycle_ctrl: RTL
====================

# multicycle_ctrl

Main control FSM of the simplified multicycle 16-bit RISC-V processor. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives the clock-enable inputs of the datapath's enable registers (PC, IR, A, B, ALUOut, MDR) together with the register-file, memory and mux controls. The FSM advances on the posedge of `clk_n`, so every enable and select is settled half a cycle before the datapath registers capture on the negedge.

## Interface
- `RESET_PC_EN_CYCLES`, default 1: number of IDLE cycles after reset release before the first FETCH; legal values 1–4.
- `clk_n`  in  1  system clock; FSM state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  4  opcode class from the IR output, `IR[15:12]`; must be stable from DECODE through WB.
- `zero`  in  1  ALU zero flag; sampled in EXEC for BRANCH.
- `mem_ready`  in  1  memory access complete.
- `pc_en`, `ir_en`, `a_en`, `b_en`, `alu_out_en`, `mdr_en`  out  1 each  register clock enables.
- `rf_we`, `mem_we`, `mem_re`  out  1 each  register-file write, memory write and memory read strobes.
- `pc_src`  out  2  PC mux select: 0 = PC+2, 1 = ALU target, 2 = jump target.
- `alu_src_b`  out  1  ALU B-operand select: 0 = B register, 1 = immediate.
- `wb_src`  out  2  write-back select: 0 = ALUOut, 1 = MDR, 2 = PC (link).
- `halted`, `illegal`  out  1 each  sticky status flags.
- `instret`  out  16  retired-instruction counter.
- `state`  out  3  current state, for debug.

## Operation
- Opcode classes: 0 R_ALU, 1 I_ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 15 HALT. All other values are illegal.
- Moore outputs decoded from state and `op`. Any strobe not listed for a state is 0.
- IDLE: all outputs 0. Stays for `RESET_PC_EN_CYCLES` cycles, then goes to FETCH.
- FETCH: `mem_re`=1. `ir_en`=`pc_en`=`mem_ready`, `pc_src`=0. Goes to DECODE when `mem_ready`=1, otherwise stays in FETCH.
- DECODE: `a_en`=`b_en`=1.
  - HALT → HALTED.
  - Illegal opcode → HALTED, and `illegal` is set.
  - Any other opcode → EXEC.
- EXEC: `alu_out_en`=1. `alu_src_b`=1 for I_ALU, LOAD and STORE.
  - BRANCH: `pc_en`=`zero`, `pc_src`=1 → FETCH.
  - JAL: `pc_en`=1, `pc_src`=2 → WB.
  - LOAD or STORE → MEM.
  - R_ALU or I_ALU → WB.
- MEM:
  - LOAD: `mem_re`=1, `mdr_en`=`mem_ready` → WB once `mem_ready` is high.
  - STORE: `mem_we`=1 → FETCH once `mem_ready` is high.
  - `mem_we` stays high while waiting for `mem_ready`.
- WB: `rf_we`=1. `wb_src` = 1 for LOAD, 2 for JAL, 0 otherwise → FETCH.
- HALTED: all enables 0, `halted`=1. Only reset leaves this state.
- `instret` increments by 1 on every transition into FETCH from EXEC, MEM or WB. It wraps from 0xFFFF to 0x0000 with no flag.

## Timing
- Reset values: state = IDLE, every enable and strobe 0, `pc_src`=`wb_src`=0, `alu_src_b`=0, `halted`=`illegal`=0, `instret`=0.
- Reset asserted mid-instruction forces IDLE immediately (asynchronous). An interrupted write strobe never completes.
- Cycles per instruction with `mem_ready` tied high:
  - R_ALU, I_ALU, JAL, STORE: 4.
  - LOAD: 5.
  - BRANCH: 3.
  - HALT: 2, then stays halted.
- Each cycle of `mem_ready`=0 in FETCH or MEM adds exactly one cycle. No enable fires during a wait cycle.
- `op` changes during FETCH are don't-care. Only DECODE through WB use `op`.

## Configuration
- `MEM_WAIT_EN` defined: FETCH and MEM stall on `mem_ready` exactly as described above.
- `MEM_WAIT_EN` undefined: `mem_ready` is ignored and treated as 1. Each memory state takes exactly one cycle. The port remains present and unused.

## Structure
- Shared package `mc_pkg` holds:
  - state encodings: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, HALTED 6;
  - opcode-class constants;
  - `pc_src` and `wb_src` encodings.
- One sub-module, `mc_instret_ctr`: 16-bit wrapping counter with increment enable and async active-low reset.
- State register and output decode live in `multicycle_ctrl`.

## Test plan
- Reset release, R_ALU (`op`=0) → states IDLE, FETCH, DECODE, EXEC, WB, FETCH.
  - `rf_we`=1 only in WB, with `wb_src`=0.
  - `instret` = 1.
- LOAD (`op`=2) with `mem_ready` low for 2 cycles in MEM, `MEM_WAIT_EN` defined → 7 cycles from FETCH to the next FETCH.
  - `mdr_en` pulses once.
  - `wb_src`=1.
- BRANCH (`op`=4), once with `zero`=1 and once with `zero`=0 → `pc_en` = 1 and 0 respectively in EXEC, with `pc_src`=1. Next state is FETCH after 3 cycles in both cases.
- `op`=7 → after DECODE, `illegal`=1 and `halted`=1 with all enables 0 for 10 cycles. Asserting `rst_n`=0 clears both flags asynchronously.
- Reset pulsed during MEM of a STORE → `mem_we` drops immediately, state is IDLE, `instret` = 0.
- Preload `instret` to 0xFFFF by running 65535 single R_ALU instructions (or force it), retire one more → `instret` = 0x0000.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control FSM: state encodings,
// opcode classes and datapath mux select encodings.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALTED = 3'd6
  } state_t;

  localparam logic [3:0] OP_R_ALU  = 4'd0;
  localparam logic [3:0] OP_I_ALU  = 4'd1;
  localparam logic [3:0] OP_LOAD   = 4'd2;
  localparam logic [3:0] OP_STORE  = 4'd3;
  localparam logic [3:0] OP_BRANCH = 4'd4;
  localparam logic [3:0] OP_JAL    = 4'd5;
  localparam logic [3:0] OP_HALT   = 4'd15;

  localparam logic [1:0] PC_SRC_PLUS2 = 2'd0;
  localparam logic [1:0] PC_SRC_ALU   = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP  = 2'd2;

  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_MDR = 2'd1;
  localparam logic [1:0] WB_SRC_PC  = 2'd2;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_JAL) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/mc_instret_ctr.sv
// 16-bit retired-instruction counter; wraps silently from 0xFFFF to 0x0000.
module mc_instret_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_r;

  // Count register, advancing by one on each retirement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 16'd0;
    end else if (inc) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle 16-bit RISC-V core (Moore decode of state and op).
// Optional feature macro MEM_WAIT_EN: when defined, FETCH and MEM stall on mem_ready.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned RESET_PC_EN_CYCLES = 1
) (
  input  logic        clk_n,
  input  logic        rst_n,
  input  logic [3:0]  op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ir_en,
  output logic        a_en,
  output logic        b_en,
  output logic        alu_out_en,
  output logic        mdr_en,
  output logic        rf_we,
  output logic        mem_we,
  output logic        mem_re,
  output logic [1:0]  pc_src,
  output logic        alu_src_b,
  output logic [1:0]  wb_src,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] instret,
  output logic [2:0]  state
);

  localparam logic [1:0] IDLE_LAST = 2'(RESET_PC_EN_CYCLES - 1);

  state_t      state_r;
  state_t      state_next_s;
  logic [1:0]  idle_cnt_r;
  logic        illegal_r;
  logic        ready_s;
  logic        retire_s;

`ifdef MEM_WAIT_EN
  assign ready_s = mem_ready;
`else
  logic mem_ready_unused_s;
  assign mem_ready_unused_s = mem_ready;
  assign ready_s = 1'b1;
`endif

  // State register
  always_ff @(posedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Post-reset IDLE dwell counter
  always_ff @(posedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_r <= 2'd0;
    end else if (state_r == ST_IDLE) begin
      idle_cnt_r <= idle_cnt_r + 2'd1;
    end else begin
      idle_cnt_r <= 2'd0;
    end
  end

  // Sticky illegal-opcode flag, raised when DECODE sees an unknown class
  always_ff @(posedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      illegal_r <= 1'b0;
    end else if ((state_r == ST_DECODE) && !is_legal_op(op)) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_next_s = state_r;
    pc_en        = 1'b0;
    ir_en        = 1'b0;
    a_en         = 1'b0;
    b_en         = 1'b0;
    alu_out_en   = 1'b0;
    mdr_en       = 1'b0;
    rf_we        = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    pc_src       = PC_SRC_PLUS2;
    alu_src_b    = 1'b0;
    wb_src       = WB_SRC_ALU;
    halted       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_next_s = (idle_cnt_r == IDLE_LAST) ? ST_FETCH : ST_IDLE;
      end
      ST_FETCH: begin
        mem_re       = 1'b1;
        ir_en        = ready_s;
        pc_en        = ready_s;
        state_next_s = ready_s ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        a_en = 1'b1;
        b_en = 1'b1;
        if (is_legal_op(op) && (op != OP_HALT)) begin
          state_next_s = ST_EXEC;
        end else begin
          state_next_s = ST_HALTED;
        end
      end
      ST_EXEC: begin
        alu_out_en = 1'b1;
        alu_src_b  = (op == OP_I_ALU) || (op == OP_LOAD) || (op == OP_STORE);
        case (op)
          OP_BRANCH: begin
            pc_en        = zero;
            pc_src       = PC_SRC_ALU;
            state_next_s = ST_FETCH;
          end
          OP_JAL: begin
            pc_en        = 1'b1;
            pc_src       = PC_SRC_JUMP;
            state_next_s = ST_WB;
          end
          OP_LOAD, OP_STORE: state_next_s = ST_MEM;
          default:           state_next_s = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (op == OP_LOAD) begin
          mem_re       = 1'b1;
          mdr_en       = ready_s;
          state_next_s = ready_s ? ST_WB : ST_MEM;
        end else begin
          mem_we       = 1'b1;
          state_next_s = ready_s ? ST_FETCH : ST_MEM;
        end
      end
      ST_WB: begin
        rf_we = 1'b1;
        if (op == OP_LOAD) begin
          wb_src = WB_SRC_MDR;
        end else if (op == OP_JAL) begin
          wb_src = WB_SRC_PC;
        end else begin
          wb_src = WB_SRC_ALU;
        end
        state_next_s = ST_FETCH;
      end
      ST_HALTED: begin
        halted       = 1'b1;
        state_next_s = ST_HALTED;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // An instruction retires when control returns to FETCH from a work state
  assign retire_s = (state_next_s == ST_FETCH) &&
                    ((state_r == ST_EXEC) || (state_r == ST_MEM) || (state_r == ST_WB));

  mc_instret_ctr u_instret (
    .clk   (clk_n),
    .rst_n (rst_n),
    .inc   (retire_s),
    .count (instret)
  );

  assign illegal = illegal_r;
  assign state   = state_r;

endmodule
